// File: rtl/config_frame_store.sv
// Parses framed, checksummed configuration packets from the UART byte stream
// into a per-A-line configuration memory with a one-cycle registered read port.
module config_frame_store #(
    parameter int         NUM_CH      = 8,
    parameter int         DELAY_W     = 16,
    parameter int         PULSE_W     = 32,
    parameter int         NUM_ALINES  = 32,
    parameter int         ALINE_W     = 5,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                uart_data,
    input  logic                      new_data,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [ALINE_W-1:0]        which_aline,
    output logic                      intaking_configs,
    output logic                      frame_done,
    output logic                      frame_err,
    output logic                      rd_valid,
    output logic                      entry_valid,
    output logic [NUM_CH-1:0]         channel_select,
    output logic [ALINE_W-1:0]        aline_select,
    output logic [PULSE_W-1:0]        pulse_shape,
    output logic [NUM_CH*DELAY_W-1:0] ch_delays
);

    localparam int PULSE_BYTES = PULSE_W / 8;
    localparam int DELAY_BYTES = NUM_CH * DELAY_W / 8;
    localparam int DLY_TOT     = NUM_CH * DELAY_W;
    localparam int CNT_W       = $clog2(DELAY_BYTES + PULSE_BYTES + 2);
    localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_ALINE, S_HDR_CH, S_PULSE, S_DELAY, S_CHECK, S_COMMIT
    } state_t;

    state_t               state_q, state_d;
    logic                 new_data_q;
    logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [7:0]           aline_q, aline_d;
    logic [NUM_CH-1:0]    chsel_q, chsel_d;
    logic [PULSE_W-1:0]   pulse_q, pulse_d;
    logic [DLY_TOT-1:0]   delay_sr_q, delay_sr_d;
    logic [7:0]           csum_acc_q, csum_acc_d;
    logic [7:0]           csum_rx_q, csum_rx_d;
    logic [NUM_ALINES-1:0] valid_q, valid_d;

    logic                 rd_valid_q, rd_valid_d;
    logic                 entry_valid_q, entry_valid_d;
    logic [NUM_CH-1:0]    rd_chsel_q, rd_chsel_d;
    logic [ALINE_W-1:0]   rd_aline_q, rd_aline_d;
    logic [PULSE_W-1:0]   rd_pulse_q, rd_pulse_d;
    logic [DLY_TOT-1:0]   rd_delay_q, rd_delay_d;

    logic [NUM_CH-1:0]    mem_chsel [NUM_ALINES];
    logic [PULSE_W-1:0]   mem_pulse [NUM_ALINES];
    logic [DLY_TOT-1:0]   mem_delay [NUM_ALINES];

    logic                 byte_acc;
    logic                 receiving;
    logic                 frame_ok;
    logic                 commit_we;
    logic [ALINE_W-1:0]   widx;
    logic [DLY_TOT-1:0]   delay_ord;

    assign byte_acc  = new_data & ~new_data_q;
    assign receiving = (state_q == S_HDR_ALINE) || (state_q == S_HDR_CH) ||
                       (state_q == S_PULSE) || (state_q == S_DELAY);
    assign frame_ok  = (csum_acc_q == csum_rx_q) && (32'(aline_q) < NUM_ALINES) && wr_en;
    assign widx      = ALINE_W'(aline_q);

    // Delay bytes arrive ch0 first, so ch0 ends up at the top of the shift register.
    always_comb begin
        delay_ord = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            delay_ord[k*DELAY_W +: DELAY_W] = delay_sr_q[(NUM_CH-1-k)*DELAY_W +: DELAY_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        to_cnt_d   = '0;
        aline_d    = aline_q;
        chsel_d    = chsel_q;
        pulse_d    = pulse_q;
        delay_sr_d = delay_sr_q;
        csum_acc_d = csum_acc_q;
        csum_rx_d  = csum_rx_q;
        valid_d    = valid_q;
        commit_we  = 1'b0;
        frame_done = 1'b0;
        frame_err  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (byte_acc && (uart_data == SYNC_BYTE)) begin
                    state_d    = S_HDR_ALINE;
                    byte_cnt_d = '0;
                    csum_acc_d = '0;
                end
            end
            S_HDR_ALINE: begin
                if (byte_acc) begin
                    aline_d    = uart_data;
                    csum_acc_d = csum_acc_q ^ uart_data;
                    state_d    = S_HDR_CH;
                end
            end
            S_HDR_CH: begin
                if (byte_acc) begin
                    chsel_d    = uart_data[NUM_CH-1:0];
                    csum_acc_d = csum_acc_q ^ uart_data;
                    byte_cnt_d = '0;
                    state_d    = S_PULSE;
                end
            end
            S_PULSE: begin
                if (byte_acc) begin
                    pulse_d    = PULSE_W'({pulse_q, uart_data});
                    csum_acc_d = csum_acc_q ^ uart_data;
                    if (byte_cnt_q == CNT_W'(PULSE_BYTES - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = S_DELAY;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            S_DELAY: begin
                // The byte following the last delay byte is the checksum.
                if (byte_acc) begin
                    if (byte_cnt_q == CNT_W'(DELAY_BYTES)) begin
                        csum_rx_d = uart_data;
                        state_d   = S_CHECK;
                    end else begin
                        delay_sr_d = DLY_TOT'({delay_sr_q, uart_data});
                        csum_acc_d = csum_acc_q ^ uart_data;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            S_CHECK: begin
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                if (frame_ok) begin
                    commit_we     = 1'b1;
                    frame_done    = 1'b1;
                    valid_d[widx] = 1'b1;
                end else begin
                    frame_err = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (receiving && !byte_acc) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                state_d   = S_IDLE;
                frame_err = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        rd_valid_d    = rd_en;
        entry_valid_d = entry_valid_q;
        rd_chsel_d    = rd_chsel_q;
        rd_aline_d    = rd_aline_q;
        rd_pulse_d    = rd_pulse_q;
        rd_delay_d    = rd_delay_q;
        if (rd_en) begin
            rd_aline_d = which_aline;
            if ((32'(which_aline) < NUM_ALINES) && valid_q[which_aline]) begin
                entry_valid_d = 1'b1;
                rd_chsel_d    = mem_chsel[which_aline];
                rd_pulse_d    = mem_pulse[which_aline];
                rd_delay_d    = mem_delay[which_aline];
            end else begin
                entry_valid_d = 1'b0;
                rd_chsel_d    = '0;
                rd_pulse_d    = '0;
                rd_delay_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            new_data_q    <= 1'b0;
            byte_cnt_q    <= '0;
            to_cnt_q      <= '0;
            aline_q       <= '0;
            chsel_q       <= '0;
            pulse_q       <= '0;
            delay_sr_q    <= '0;
            csum_acc_q    <= '0;
            csum_rx_q     <= '0;
            valid_q       <= '0;
            rd_valid_q    <= 1'b0;
            entry_valid_q <= 1'b0;
            rd_chsel_q    <= '0;
            rd_aline_q    <= '0;
            rd_pulse_q    <= '0;
            rd_delay_q    <= '0;
        end else begin
            state_q       <= state_d;
            new_data_q    <= new_data;
            byte_cnt_q    <= byte_cnt_d;
            to_cnt_q      <= to_cnt_d;
            aline_q       <= aline_d;
            chsel_q       <= chsel_d;
            pulse_q       <= pulse_d;
            delay_sr_q    <= delay_sr_d;
            csum_acc_q    <= csum_acc_d;
            csum_rx_q     <= csum_rx_d;
            valid_q       <= valid_d;
            rd_valid_q    <= rd_valid_d;
            entry_valid_q <= entry_valid_d;
            rd_chsel_q    <= rd_chsel_d;
            rd_aline_q    <= rd_aline_d;
            rd_pulse_q    <= rd_pulse_d;
            rd_delay_q    <= rd_delay_d;
        end
    end

    // Memory contents survive reset; the valid bits mask stale entries.
    always_ff @(posedge clk) begin
        if (commit_we) begin
            mem_chsel[widx] <= chsel_q;
            mem_pulse[widx] <= pulse_q;
            mem_delay[widx] <= delay_ord;
        end
    end

    assign intaking_configs = receiving || (state_q == S_CHECK);
    assign rd_valid         = rd_valid_q;
    assign entry_valid      = entry_valid_q;
    assign channel_select   = rd_chsel_q;
    assign aline_select     = rd_aline_q;
    assign pulse_shape      = rd_pulse_q;
    assign ch_delays        = rd_delay_q;

endmodule

// File: tb/tb_config_frame_store.sv
// Randomised bench for config_frame_store: frames are built as byte queues and
// checked against an array model of the configuration memory.
module tb_config_frame_store;

    localparam int NUM_CH      = 8;
    localparam int DELAY_W     = 16;
    localparam int PULSE_W     = 32;
    localparam int NUM_ALINES  = 32;
    localparam int ALINE_W     = 5;
    localparam int TIMEOUT_CYC = 50;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [7:0]                uart_data;
    logic                      new_data;
    logic                      wr_en;
    logic                      rd_en;
    logic [ALINE_W-1:0]        which_aline;
    logic                      intaking_configs;
    logic                      frame_done;
    logic                      frame_err;
    logic                      rd_valid;
    logic                      entry_valid;
    logic [NUM_CH-1:0]         channel_select;
    logic [ALINE_W-1:0]        aline_select;
    logic [PULSE_W-1:0]        pulse_shape;
    logic [NUM_CH*DELAY_W-1:0] ch_delays;

    config_frame_store #(
        .NUM_CH(NUM_CH), .DELAY_W(DELAY_W), .PULSE_W(PULSE_W),
        .NUM_ALINES(NUM_ALINES), .ALINE_W(ALINE_W),
        .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .uart_data(uart_data), .new_data(new_data),
        .wr_en(wr_en), .rd_en(rd_en), .which_aline(which_aline),
        .intaking_configs(intaking_configs), .frame_done(frame_done),
        .frame_err(frame_err), .rd_valid(rd_valid), .entry_valid(entry_valid),
        .channel_select(channel_select), .aline_select(aline_select),
        .pulse_shape(pulse_shape), .ch_delays(ch_delays)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit          ref_valid [NUM_ALINES];
    logic [7:0]  ref_chsel [NUM_ALINES];
    logic [31:0] ref_pulse [NUM_ALINES];
    logic [15:0] ref_dly   [NUM_ALINES][NUM_CH];

    logic [7:0]  f_aline;
    logic [7:0]  f_chsel;
    logic [31:0] f_pulse;
    logic [15:0] f_dly [NUM_CH];
    bit          f_corrupt;
    logic [7:0]  frame_q [$];

    int cyc = 0;
    int last_err_cyc = 0;
    int last_drive_cyc = 0;
    int seen_done = 0, seen_err = 0;
    int exp_done = 0, exp_err = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_done) seen_done++;
        if (frame_err) begin
            seen_err++;
            last_err_cyc = cyc;
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One byte per 100-unit period of new_data: high for 5 clocks, low for 5.
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        last_drive_cyc = cyc;
        uart_data = b;
        new_data  = 1'b1;
        repeat (5) @(negedge clk);
        new_data = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic build_frame();
        logic [7:0] cs;
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(f_aline);
        frame_q.push_back(f_chsel);
        for (int i = 3; i >= 0; i--) frame_q.push_back(f_pulse[i*8 +: 8]);
        for (int k = 0; k < NUM_CH; k++) begin
            frame_q.push_back(f_dly[k][15:8]);
            frame_q.push_back(f_dly[k][7:0]);
        end
        cs = 8'h00;
        for (int i = 1; i < frame_q.size(); i++) cs = cs ^ frame_q[i];
        if (f_corrupt) cs = cs ^ 8'h01;
        frame_q.push_back(cs);
    endtask

    task automatic random_fields(input logic [7:0] aline);
        f_aline = aline;
        f_chsel = 8'($urandom);
        f_pulse = $urandom;
        for (int k = 0; k < NUM_CH; k++) f_dly[k] = 16'($urandom);
        f_corrupt = 1'b0;
    endtask

    function automatic logic [127:0] exp_delays(input int a);
        logic [127:0] v = '0;
        if (ref_valid[a])
            for (int k = 0; k < NUM_CH; k++) v[k*DELAY_W +: DELAY_W] = ref_dly[a][k];
        return v;
    endfunction

    task automatic compare_read(input int a, input string tag);
        checkOutput({tag, "_rd_valid"}, rd_valid, 1);
        checkOutput({tag, "_aline_sel"}, aline_select, a);
        checkOutput({tag, "_entry_valid"}, entry_valid, ref_valid[a]);
        checkOutput({tag, "_chsel"}, channel_select, ref_valid[a] ? ref_chsel[a] : 8'h00);
        checkOutput({tag, "_pulse"}, pulse_shape, ref_valid[a] ? ref_pulse[a] : 32'h0);
        checkOutput({tag, "_delays"}, ch_delays, exp_delays(a));
    endtask

    task automatic read_check(input int a, input string tag);
        @(negedge clk);
        rd_en = 1'b1;
        which_aline = ALINE_W'(a);
        @(negedge clk);
        rd_en = 1'b0;
        compare_read(a, tag);
        @(negedge clk);
        checkOutput({tag, "_rd_valid_drop"}, rd_valid, 0);
    endtask

    task automatic send_frame(input bit read_at_commit, input string tag);
        bit exp_ok;
        int a;
        exp_ok = !f_corrupt && (f_aline < NUM_ALINES) && wr_en;
        a = int'(f_aline) % NUM_ALINES;
        @(negedge clk);
        uart_data = frame_q[0];
        new_data  = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_intake_rise"}, intaking_configs, 1);
        repeat (4) @(negedge clk);
        new_data = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 1; i < frame_q.size() - 1; i++) applyStimulus(frame_q[i]);
        @(negedge clk);
        uart_data = frame_q[frame_q.size()-1];
        new_data  = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            if (j == 1) begin
                checkOutput({tag, "_check_intaking"}, intaking_configs, 1);
                checkOutput({tag, "_check_no_pulse"}, {frame_done, frame_err}, 2'b00);
            end
            if (j == 2) begin
                checkOutput({tag, "_done"}, frame_done, exp_ok);
                checkOutput({tag, "_err"}, frame_err, !exp_ok);
                checkOutput({tag, "_intaking_low"}, intaking_configs, 0);
                if (read_at_commit) begin
                    rd_en = 1'b1;
                    which_aline = ALINE_W'(a);
                end
            end
            if (j == 3) begin
                if (read_at_commit) compare_read(a, {tag, "_rd_old"});
                if (exp_ok) begin
                    ref_valid[a] = 1'b1;
                    ref_chsel[a] = f_chsel;
                    ref_pulse[a] = f_pulse;
                    for (int k = 0; k < NUM_CH; k++) ref_dly[a][k] = f_dly[k];
                end
            end
            if (j == 4 && read_at_commit) begin
                rd_en = 1'b0;
                compare_read(a, {tag, "_rd_new"});
            end
            if (j == 5) new_data = 1'b0;
        end
        if (exp_ok) exp_done++;
        else exp_err++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NUM_ALINES; i++) ref_valid[i] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int err_before;
        int lat;
        logic [7:0] g;
        rst = 1'b1;
        uart_data = 8'h00;
        new_data = 1'b0;
        wr_en = 1'b1;
        rd_en = 1'b0;
        which_aline = '0;
        for (int i = 0; i < NUM_ALINES; i++) ref_valid[i] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("rst_intaking", intaking_configs, 0);
        checkOutput("rst_pulses", {frame_done, frame_err, rd_valid}, 3'b000);
        checkOutput("rst_entry_valid", entry_valid, 0);
        checkOutput("rst_read_data", {channel_select, aline_select, pulse_shape}, 0);
        checkOutput("rst_delays", ch_delays, 0);

        // Reference frame from the datasheet, first with a bad checksum.
        f_aline = 8'h03; f_chsel = 8'h1B; f_pulse = 32'h0000FFFF;
        for (int k = 0; k < NUM_CH; k++) f_dly[k] = 16'h0100 + 16'(k);
        f_corrupt = 1'b1;
        build_frame();
        send_frame(0, "bad_csum");
        read_check(3, "bad_csum_rd");

        f_corrupt = 1'b0;
        build_frame();
        send_frame(0, "good");
        read_check(3, "good_rd");
        checkOutput("good_ch0", ch_delays[15:0], 16'h0100);
        checkOutput("good_ch7", ch_delays[127:112], 16'h0107);

        f_aline = 8'h25;
        build_frame();
        send_frame(0, "aline_oor");
        random_fields(8'd5);
        build_frame();
        wr_en = 1'b0;
        send_frame(0, "wr_dis");
        wr_en = 1'b1;
        read_check(5, "wr_dis_rd");
        read_check(3, "still3_rd");

        // Stall after 10 bytes and wait for the inter-byte timeout.
        random_fields(8'd4);
        build_frame();
        for (int i = 0; i < 10; i++) applyStimulus(frame_q[i]);
        err_before = seen_err;
        for (int t = 0; t < 100 && seen_err == err_before; t++) @(negedge clk);
        @(negedge clk);
        lat = last_err_cyc - last_drive_cyc;
        checkOutput("timeout_err_count", seen_err - err_before, 1);
        checkOutput("timeout_latency_ok", (lat == TIMEOUT_CYC) || (lat == TIMEOUT_CYC + 1), 1);
        checkOutput("timeout_intaking", intaking_configs, 0);
        exp_err++;
        random_fields(8'd7);
        build_frame();
        send_frame(0, "after_to");
        read_check(7, "after_to_rd");

        // Reset in the middle of a frame after aline 3 was committed.
        read_check(3, "pre_rst_rd");
        random_fields(8'd9);
        build_frame();
        for (int i = 0; i < 12; i++) applyStimulus(frame_q[i]);
        do_reset();
        checkOutput("midrst_intaking", intaking_configs, 0);
        checkOutput("midrst_flags", {rd_valid, entry_valid}, 2'b00);
        checkOutput("midrst_data", {channel_select, aline_select, pulse_shape}, 0);
        checkOutput("midrst_delays", ch_delays, 0);
        read_check(3, "midrst_rd3");
        random_fields(8'd3);
        build_frame();
        send_frame(1, "post_rst");
        random_fields(8'd3);
        build_frame();
        send_frame(1, "overwrite3");

        for (int n = 0; n < 16; n++) begin
            for (int gb = 0; gb < int'($urandom_range(0, 2)); gb++) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                applyStimulus(g);
            end
            random_fields(8'($urandom_range(0, 39)));
            f_corrupt = ($urandom_range(0, 6) == 0);
            wr_en = ($urandom_range(0, 5) != 0);
            build_frame();
            send_frame(($urandom_range(0, 2) == 0) && (f_aline < NUM_ALINES), $sformatf("rnd%0d", n));
            wr_en = 1'b1;
            read_check($urandom_range(0, NUM_ALINES - 1), $sformatf("rnd%0d_rd", n));
        end

        for (int a = 0; a < NUM_ALINES; a++) read_check(a, $sformatf("sweep%0d", a));

        checkOutput("total_done", seen_done, exp_done);
        checkOutput("total_err", seen_err, exp_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/config_frame_store.md
# config_frame_store

Parametrised successor to the single-set configuration store. It parses framed, checksummed configuration packets from the UART byte stream into a per-A-line configuration memory. Each entry holds a channel select, a pulse shape and NUM_CH channel delays. Downstream pulser/delay logic reads any A-line's entry on request. The block sits between the UART receiver and the per-channel delay/pulse generators.

## Interface
- NUM_CH, 8, channel count (1..8); width of channel_select and number of delays
- DELAY_W, 16, bits per channel delay (multiple of 8)
- PULSE_W, 32, pulse shape bits (multiple of 8)
- NUM_ALINES, 32, configuration memory depth
- ALINE_W, 5, A-line index width (2^ALINE_W >= NUM_ALINES)
- SYNC_BYTE, 8'hA5, frame start byte
- TIMEOUT_CYC, 100000, idle cycles allowed between bytes inside a frame

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- uart_data  in  8  received byte, valid when new_data rises
- new_data  in  1  byte strobe; a byte is taken on each rising edge (level or pulse both legal)
- wr_en  in  1  commit enable, sampled in COMMIT
- rd_en  in  1  read request
- which_aline  in  ALINE_W  read address
- intaking_configs  out  1  high while a frame is being received/checked
- frame_done  out  1  1-cycle pulse: entry written
- frame_err  out  1  1-cycle pulse: frame discarded
- rd_valid  out  1  1-cycle pulse: read outputs updated
- entry_valid  out  1  read entry has been written since reset
- channel_select  out  NUM_CH  read data
- aline_select  out  ALINE_W  index of the read data
- pulse_shape  out  PULSE_W  read data
- ch_delays  out  NUM_CH*DELAY_W  read data; ch k at [k*DELAY_W +: DELAY_W]

## Operation
- Byte accept: new_data & ~new_data_q (new_data_q is a registered copy of new_data).
- Frame: SYNC, aline index byte, channel-select byte (low NUM_CH bits used), PULSE_W/8 pulse bytes MSB first, then ch0..ch(NUM_CH-1) delays (DELAY_W/8 bytes each, MSB first), checksum byte.
- Checksum: XOR of every byte after SYNC, excluding the checksum byte. Default frame length is 24 bytes.
- FSM states: IDLE -> HDR_ALINE -> HDR_CH -> PULSE -> DELAY -> CHECK -> COMMIT -> IDLE.
  - Byte counter selects the PULSE and DELAY byte slots.
  - Fields are assembled in a shadow register; memory is untouched until COMMIT.
- IDLE: non-SYNC bytes are ignored. A SYNC byte inside a frame is treated as data; there is no resync.
- CHECK -> COMMIT always. COMMIT writes the shadow register to memory[aline] and pulses frame_done only if all of these hold: checksum matches, aline < NUM_ALINES, wr_en = 1. It then sets valid[aline].
- Any other outcome pulses frame_err and leaves memory unchanged.
- Timeout: in any non-IDLE state before CHECK, TIMEOUT_CYC consecutive cycles with no accepted byte -> frame_err, IDLE. The counter clears on every accepted byte.
- Read: rd_en sampled each cycle.
  - Next cycle: outputs are loaded from memory[which_aline], aline_select = which_aline, entry_valid = valid bit, and rd_valid pulses.
  - Unwritten or out-of-range entry: data outputs 0, entry_valid 0.
  - Outputs hold between reads.
- Read and commit to the same address in the same cycle: the read returns the pre-commit data.
- Reset (any time, including mid-frame): FSM to IDLE; all outputs 0; all valid bits cleared; shadow register and counters cleared. Memory data is not cleared but is masked by the valid bits.

## Timing
- Last (checksum) byte edge seen in cycle k -> CHECK in cycle k+1 -> COMMIT in cycle k+2.
- frame_done/frame_err are high during cycle k+2 only. intaking_configs is low from k+2.
- intaking_configs rises the cycle after the SYNC byte edge is seen.
- Read latency: 1 cycle, rd_en high in cycle n -> data and rd_valid in cycle n+1. Back-to-back reads are allowed every cycle.
- rd_en is independent of frame reception; no stall in either direction.

## Test plan
- Good frame, defaults, wr_en = 1. Stimulus: A5, 03, 1B, 00 00 FF FF, delays ch k = 16'h0100+k, checksum 18. Response: one frame_done pulse. Reading aline 3 gives channel_select 8'h1B, pulse_shape 32'h0000FFFF, ch_delays[15:0] = 16'h0100, top slice = 16'h0107, entry_valid 1.
- Same frame with checksum 19 -> frame_err pulse, no frame_done; reading aline 3 gives all zeros, entry_valid 0.
- Good frame with aline byte 8'h25 (37 >= 32) -> frame_err. Good frame with wr_en = 0 -> frame_err. Neither writes memory.
- Frame stalls after 10 bytes for TIMEOUT_CYC cycles (reduce to 50 in the bench) -> frame_err, intaking_configs low. A following good frame commits normally.
- rst asserted at byte 12 of a frame, after an earlier commit to aline 3 -> outputs 0, entry_valid 0 on read of aline 3. The next complete frame commits.
- Read aline 3 in the exact COMMIT cycle of a new frame to aline 3 -> old data returned. A read one cycle later returns new data.
- Bench drives new_data as a 100 ns period toggling level with a 10 ns clk; exactly one byte must be accepted per rising edge.
